route_demux_n: RTL and testbench

Parametrised header-match packet demultiplexer for the on-chip router input stage. Holds a table of NOUT-1 programmable (addr, mask) rules. Routes each incoming flit to the lowest-index output whose rule matches the flit header, or to the default output NOUT-1 when no rule matches. Adds an enqueue FIFO, valid/ready handshakes on every port, and a drain-then-reconfigure mode, all clocked RTL.

---
 rtl/route_demux_n.sv | 142 ++++++++++++++
 tb/tb_route_demux_n.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/route_demux_n.sv
// Header-match packet demultiplexer: programmable (addr, mask) rules, route tagged at enqueue,
// single shared FIFO feeding NOUT valid/ready channels, with a drain-then-reconfigure FSM.
module route_demux_n #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned NOUT   = 3,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned IDX_W = (NOUT > 2) ? $clog2(NOUT - 1) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [ADDR_W-1:0] cfg_mask,
  input  logic              cfg_en,
  input  logic              cfg_last,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [NOUT-1:0]   out_valid,
  input  logic [NOUT-1:0]   out_ready,
  output logic [DATA_W-1:0] out_data
);

  localparam int unsigned ROUTE_W = $clog2(NOUT);
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned NRULE   = NOUT - 1;

  typedef enum logic [1:0] {StCfg, StRun, StDrain} state_e;

  state_e              r_state;
  state_e              w_state_d;
  logic                r_cfg_ready;
  logic                r_in_ready;

  logic [ADDR_W-1:0]   r_addr [NRULE];
  logic [ADDR_W-1:0]   r_mask [NRULE];
  logic [NRULE-1:0]    r_en;

  logic [DATA_W-1:0]   r_mem       [DEPTH];
  logic [ROUTE_W-1:0]  r_mem_route [DEPTH];
  logic [PTR_W-1:0]    r_wptr;
  logic [PTR_W-1:0]    r_rptr;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    w_count_d;

  logic [ADDR_W-1:0]   w_hdr;
  logic [NRULE-1:0]    w_hit;
  logic [ROUTE_W-1:0]  w_route;
  logic                w_nonempty;
  logic                w_push;
  logic                w_pop;
  logic                w_cfg_we;

  assign w_hdr      = in_data[DATA_W-1 -: ADDR_W];
  assign w_nonempty = (r_count != '0);
  assign w_push     = in_valid & r_in_ready;
  assign w_pop      = |(out_valid & out_ready);
  assign w_cfg_we   = (r_state == StCfg) & cfg_valid &
                      ({1'b0, cfg_idx} < (IDX_W + 1)'(NRULE));

  assign cfg_ready  = r_cfg_ready;
  assign in_ready   = r_in_ready;

  // Lowest-index hitting rule wins; no hit falls through to the default channel.
  always_comb begin
    w_route = ROUTE_W'(NOUT - 1);
    for (int i = 0; i < int'(NRULE); i++) begin
      w_hit[i] = r_en[i] && ((w_hdr & r_mask[i]) == r_addr[i]);
    end
    for (int i = int'(NRULE) - 1; i >= 0; i--) begin
      if (w_hit[i]) w_route = ROUTE_W'(i);
    end
  end

  always_comb begin
    out_valid = '0;
    out_data  = '0;
    if (w_nonempty) begin
      out_valid[r_mem_route[r_rptr]] = 1'b1;
      out_data                       = r_mem[r_rptr];
    end
  end

  always_comb begin
    w_count_d = r_count;
    if (w_push && !w_pop) w_count_d = r_count + 1'b1;
    if (w_pop && !w_push) w_count_d = r_count - 1'b1;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StCfg:   if (cfg_valid && cfg_last) w_state_d = StRun;
      StRun:   if (cfg_valid) w_state_d = StDrain;
      StDrain: if (r_count == '0) w_state_d = StCfg;
      default: w_state_d = StCfg;
    endcase
  end

  // Handshake readies are registered from next-state so they never depend on in_valid/out_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StCfg;
      r_cfg_ready <= 1'b1;
      r_in_ready  <= 1'b0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_en        <= '0;
      for (int i = 0; i < int'(NRULE); i++) begin
        r_addr[i] <= '0;
        r_mask[i] <= '0;
      end
    end else begin
      r_state     <= w_state_d;
      r_cfg_ready <= (w_state_d == StCfg);
      r_in_ready  <= (w_state_d == StRun) && (w_count_d != CNT_W'(DEPTH));
      r_count     <= w_count_d;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      for (int i = 0; i < int'(NRULE); i++) begin
        if (w_cfg_we && (cfg_idx == IDX_W'(i))) begin
          r_addr[i] <= cfg_addr;
          r_mask[i] <= cfg_mask;
          r_en[i]   <= cfg_en;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr]       <= in_data;
      r_mem_route[r_wptr] <= w_route;
    end
  end

endmodule

// File: tb/tb_route_demux_n.sv
// Directed self-checking bench for route_demux_n with default parameters (NOUT=3, DEPTH=4).
module tb_route_demux_n;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [0:0]  cfg_idx;
  logic [7:0]  cfg_addr;
  logic [7:0]  cfg_mask;
  logic        cfg_en;
  logic        cfg_last;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [2:0]  out_valid;
  logic [2:0]  out_ready;
  logic [15:0] out_data;

  int n_checks = 0;
  int n_fail   = 0;

  route_demux_n dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_idx   (cfg_idx),
    .cfg_addr  (cfg_addr),
    .cfg_mask  (cfg_mask),
    .cfg_en    (cfg_en),
    .cfg_last  (cfg_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic cfg_write(input logic [0:0] idx, input logic [7:0] addr, input logic [7:0] mask,
                           input logic en, input logic last);
    int waited = 0;
    cfg_valid = 1'b1;
    cfg_idx   = idx;
    cfg_addr  = addr;
    cfg_mask  = mask;
    cfg_en    = en;
    cfg_last  = last;
    while (cfg_ready !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    if (waited >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL cfg_write_timeout: cfg_ready=%b required 1", cfg_ready);
    end
    tick();
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  task automatic send(input logic [15:0] d);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (in_ready !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    if (waited >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready=%b required 1 (data %h)", in_ready, d);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic std_config();
    cfg_write(1'b0, 8'h12, 8'hFF, 1'b1, 1'b0);
    cfg_write(1'b1, 8'h30, 8'hF0, 1'b1, 1'b1);
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h1234;
    tick();
    reset = 1'b0;
    n_checks++;
    if (out_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_out_data: got %h required 0000", out_data);
    end
    for (int c = 0; c < 6; c++) begin
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 3'b000 || cfg_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_idle cyc%0d: in_ready=%b out_valid=%b cfg_ready=%b required 0 000 1",
                 c, in_ready, out_valid, cfg_ready);
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_routing();
    logic [15:0] d   [3] = '{16'h12AB, 16'h3F01, 16'h5500};
    logic [2:0]  exp [3] = '{3'b001, 3'b010, 3'b100};
    do_reset();
    std_config();
    n_checks++;
    if (in_ready !== 1'b1 || cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL run_entry: in_ready=%b cfg_ready=%b required 1 0", in_ready, cfg_ready);
    end
    out_ready = 3'b111;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = d[k];
      tick();
      n_checks++;
      if (out_valid !== exp[k] || out_data !== d[k]) begin
        n_fail++;
        $display("FAIL routing flit%0d: out_valid=%b out_data=%h required %b %h",
                 k, out_valid, out_data, exp[k], d[k]);
      end
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 3'b000) begin
      n_fail++;
      $display("FAIL routing_empty: out_valid=%b required 000", out_valid);
    end
  endtask

  task automatic test_priority();
    do_reset();
    cfg_write(1'b0, 8'h30, 8'hF0, 1'b1, 1'b0);
    cfg_write(1'b1, 8'h34, 8'hFF, 1'b1, 1'b1);
    out_ready = 3'b111;
    send(16'h3400);
    n_checks++;
    if (out_valid !== 3'b001 || out_data !== 16'h3400) begin
      n_fail++;
      $display("FAIL priority: out_valid=%b out_data=%h required 001 3400", out_valid, out_data);
    end
    send(16'h4400);
    n_checks++;
    if (out_valid !== 3'b100) begin
      n_fail++;
      $display("FAIL priority_default: out_valid=%b required 100", out_valid);
    end
  endtask

  task automatic test_disabled();
    do_reset();
    // rule1 has addr bits outside its mask, so it can never hit
    cfg_write(1'b0, 8'h12, 8'hFF, 1'b0, 1'b0);
    cfg_write(1'b1, 8'h13, 8'hF0, 1'b1, 1'b1);
    out_ready = 3'b111;
    send(16'h1200);
    n_checks++;
    if (out_valid !== 3'b100) begin
      n_fail++;
      $display("FAIL disabled_rule: out_valid=%b required 100", out_valid);
    end
    send(16'h1300);
    n_checks++;
    if (out_valid !== 3'b100) begin
      n_fail++;
      $display("FAIL addr_outside_mask: out_valid=%b required 100", out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] d   [5] = '{16'h1201, 16'h3002, 16'h5503, 16'h1204, 16'h7705};
    logic [2:0]  exp [5] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b100};
    do_reset();
    std_config();
    out_ready = 3'b000;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_accept%0d: in_ready=%b required 1", k, in_ready);
      end
      in_valid = 1'b1;
      in_data  = d[k];
      tick();
    end
    in_data = d[4];
    tick();
    tick();
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== exp[0] || out_data !== d[0]) begin
      n_fail++;
      $display("FAIL bp_full: in_ready=%b out_valid=%b out_data=%h required 0 %b %h",
               in_ready, out_valid, out_data, exp[0], d[0]);
    end
    out_ready = 3'b111;
    tick();
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_unfull: in_ready=%b required 1", in_ready);
    end
    for (int k = 1; k < 5; k++) begin
      n_checks++;
      if (out_valid !== exp[k] || out_data !== d[k]) begin
        n_fail++;
        $display("FAIL bp_order%0d: out_valid=%b out_data=%h required %b %h",
                 k, out_valid, out_data, exp[k], d[k]);
      end
      tick();
      in_valid = 1'b0;
    end
    n_checks++;
    if (out_valid !== 3'b000) begin
      n_fail++;
      $display("FAIL bp_drained: out_valid=%b required 000", out_valid);
    end
  endtask

  task automatic test_reconfig();
    do_reset();
    std_config();
    out_ready = 3'b000;
    send(16'h1211);
    in_valid  = 1'b1;
    in_data   = 16'h3022;
    cfg_valid = 1'b1;
    cfg_last  = 1'b1;
    tick();
    in_valid  = 1'b0;
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    tick();
    n_checks++;
    if (in_ready !== 1'b0 || cfg_ready !== 1'b0 || out_valid !== 3'b001 ||
        out_data !== 16'h1211) begin
      n_fail++;
      $display("FAIL drain_hold: in_ready=%b cfg_ready=%b out_valid=%b out_data=%h required 0 0 001 1211",
               in_ready, cfg_ready, out_valid, out_data);
    end
    out_ready = 3'b111;
    tick();
    n_checks++;
    if (out_valid !== 3'b010 || out_data !== 16'h3022 || cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_second: out_valid=%b out_data=%h cfg_ready=%b required 010 3022 0",
               out_valid, out_data, cfg_ready);
    end
    tick();
    n_checks++;
    if (out_valid !== 3'b000 || cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_empty: out_valid=%b cfg_ready=%b required 000 0", out_valid, cfg_ready);
    end
    tick();
    n_checks++;
    if (cfg_ready !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_to_cfg: cfg_ready=%b in_ready=%b required 1 0", cfg_ready, in_ready);
    end
    cfg_write(1'b0, 8'h12, 8'hFF, 1'b0, 1'b0);
    cfg_write(1'b1, 8'h12, 8'hFF, 1'b1, 1'b1);
    send(16'h1233);
    n_checks++;
    if (out_valid !== 3'b010 || out_data !== 16'h1233) begin
      n_fail++;
      $display("FAIL new_rule: out_valid=%b out_data=%h required 010 1233", out_valid, out_data);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    std_config();
    out_ready = 3'b000;
    send(16'h1201);
    send(16'h3002);
    send(16'h5503);
    reset = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 3'b000 || out_data !== 16'h0000 || cfg_ready !== 1'b1 ||
        in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: out_valid=%b out_data=%h cfg_ready=%b in_ready=%b required 000 0000 1 0",
               out_valid, out_data, cfg_ready, in_ready);
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 3'b000) begin
      n_fail++;
      $display("FAIL mid_reset_flushed: out_valid=%b required 000", out_valid);
    end
    cfg_write(1'b0, 8'h12, 8'hFF, 1'b0, 1'b0);
    cfg_write(1'b1, 8'h00, 8'h00, 1'b0, 1'b1);
    out_ready = 3'b111;
    send(16'h1244);
    n_checks++;
    if (out_valid !== 3'b100 || out_data !== 16'h1244) begin
      n_fail++;
      $display("FAIL mid_reset_route: out_valid=%b out_data=%h required 100 1244",
               out_valid, out_data);
    end
  endtask

  initial begin
    reset     = 1'b1;
    cfg_valid = 1'b0;
    cfg_idx   = '0;
    cfg_addr  = '0;
    cfg_mask  = '0;
    cfg_en    = 1'b0;
    cfg_last  = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 3'b000;
    test_reset();
    test_routing();
    test_priority();
    test_disabled();
    test_backpressure();
    test_reconfig();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
